// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and filters the PS/2 clock, deserialises
// device-to-host frames, decodes set-2 make/break/E0 sequences and tracks
// held game keys as level outputs (up/down/right/left/pause).
module ps2_key_rx #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       up,
    output logic       down,
    output logic       right,
    output logic       left,
    output logic       pause,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_break,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int FLT_W = $clog2(FILTER_LEN + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int KEYS  = 9;

    // {extended, scan code} of each tracked key; the index is the held-flag slot.
    // 0:W 1:Up 2:S 3:Down 4:A 5:Left 6:D 7:Right 8:Space
    localparam logic [8:0] KEY_MAP [KEYS] = '{
        9'h01D, 9'h175, 9'h01B, 9'h172, 9'h01C, 9'h16B, 9'h023, 9'h174, 9'h029
    };

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    logic             clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
    logic             filt_q, fall_q;
    logic [FLT_W-1:0] flt_cnt_q;

    state_t           state_q, state_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             byte_rdy_q, byte_rdy_d;
    logic             err_q, err_d;

    logic             ext_pend_q, brk_pend_q;
    logic [7:0]       key_code_q;
    logic             key_ext_q, key_break_q, key_valid_q;
    logic             key_evt;
    logic [KEYS-1:0]  hit;
    logic [KEYS-1:0]  held_q;

    // Two-flop synchronisers; idle bus level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= ps2_data;
            data_sync_q <= data_meta_q;
        end
    end

    // Glitch filter: commit a new clock level after FILTER_LEN equal samples,
    // and flag the 1->0 commit as a one-cycle fall.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q    <= 1'b1;
            flt_cnt_q <= '0;
            fall_q    <= 1'b0;
        end else begin
            fall_q <= 1'b0;
            if (clk_sync_q == filt_q) begin
                flt_cnt_q <= '0;
            end else if (flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
                filt_q    <= clk_sync_q;
                flt_cnt_q <= '0;
                fall_q    <= filt_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + FLT_W'(1);
            end
        end
    end

    // Receive FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            byte_rdy_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            to_cnt_q   <= to_cnt_d;
            byte_rdy_q <= byte_rdy_d;
            err_q      <= err_d;
        end
    end

    // Receive FSM next state: start/data/parity/stop bits sampled on each fall,
    // with an inactivity timeout that abandons a stalled frame.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        byte_rdy_d = 1'b0;
        err_d      = 1'b0;
        to_cnt_d   = (state_q == S_IDLE || fall_q) ? '0 : to_cnt_q + TO_W'(1);

        case (state_q)
            S_IDLE: begin
                if (fall_q) begin
                    if (data_sync_q) begin
                        err_d = 1'b1;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (fall_q) begin
                    shift_d[bit_cnt_q] = data_sync_q;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (fall_q) begin
                    par_d   = data_sync_q;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (fall_q) begin
                    if (data_sync_q && ((^shift_q) ^ par_q)) begin
                        byte_rdy_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_q != S_IDLE && !fall_q && to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
            err_d    = 1'b1;
            state_d  = S_IDLE;
            to_cnt_d = '0;
        end
    end

    // Scan-code decoder: E0/F0 arm the pending flags, any other byte is a key event.
    always_ff @(posedge clk) begin
        if (rst) begin
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_break_q <= 1'b0;
            key_valid_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (byte_rdy_q) begin
                if (shift_q == 8'hE0) begin
                    ext_pend_q <= 1'b1;
                end else if (shift_q == 8'hF0) begin
                    brk_pend_q <= 1'b1;
                end else begin
                    key_code_q  <= shift_q;
                    key_ext_q   <= ext_pend_q;
                    key_break_q <= brk_pend_q;
                    key_valid_q <= 1'b1;
                    ext_pend_q  <= 1'b0;
                    brk_pend_q  <= 1'b0;
                end
            end else if (err_q) begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
            end
        end
    end

    assign key_evt = byte_rdy_q && (shift_q != 8'hE0) && (shift_q != 8'hF0);

    genvar gi;
    generate
        for (gi = 0; gi < KEYS; gi++) begin : g_match
            assign hit[gi] = key_evt && ({ext_pend_q, shift_q} == KEY_MAP[gi]);
        end
    endgenerate

    // Held flags: make sets, break clears; repeats of a make change nothing.
    always_ff @(posedge clk) begin
        if (rst) begin
            held_q <= '0;
        end else begin
            for (int i = 0; i < KEYS; i++) begin
                if (hit[i]) begin
                    held_q[i] <= !brk_pend_q;
                end
            end
        end
    end

    assign up        = held_q[0] | held_q[1];
    assign down      = held_q[2] | held_q[3];
    assign left      = held_q[4] | held_q[5];
    assign right     = held_q[6] | held_q[7];
    assign pause     = held_q[8];
    assign key_code  = key_code_q;
    assign key_ext   = key_ext_q;
    assign key_break = key_break_q;
    assign key_valid = key_valid_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: directed scenarios followed by random key sequences,
// every frame checked against a byte-level keyboard model.
module tb_ps2_key_rx;

    localparam int FLT  = 8;
    localparam int TO   = 1000;   // shortened timeout keeps the run small
    localparam int HALF = 20;     // PS/2 half period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       up, down, right, left, pause;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, frame_err;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int kv_cnt = 0;
    int fe_cnt = 0;

    // byte-level model state
    bit         held [512];
    bit         m_ext, m_brk;
    logic [7:0] m_code;
    bit         m_kext, m_kbrk;
    logic [8:0] key_tab [9];

    ps2_key_rx #(.FILTER_LEN(FLT), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .up(up), .down(down), .right(right), .left(left), .pause(pause),
        .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
        .key_valid(key_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // count strobe cycles
    always @(posedge clk) begin
        if (key_valid) kv_cnt <= kv_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        cycles(HALF);
        ps2_clk = 1'b0;
        cycles(HALF);
        ps2_clk = 1'b1;
    endtask

    // bad: 0 good frame, 1 inverted parity, 2 stop bit 0
    task automatic send_frame(input logic [7:0] b, input int bad);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ (bad == 1));
        ps2_bit(bad != 2);
        ps2_data = 1'b1;
        cycles(HALF);
    endtask

    task automatic model_reset();
        foreach (held[i]) held[i] = 1'b0;
        m_ext = 0; m_brk = 0; m_code = '0; m_kext = 0; m_kbrk = 0;
    endtask

    function automatic logic [4:0] exp_lvl();
        return {held[9'h01D] | held[9'h175], held[9'h01B] | held[9'h172],
                held[9'h023] | held[9'h174], held[9'h01C] | held[9'h16B],
                held[9'h029]};
    endfunction

    task automatic xfer(input logic [7:0] b, input int bad);
        int kv0, fe0;
        bit exp_kv, exp_fe;
        kv0 = kv_cnt; fe0 = fe_cnt;
        exp_kv = 0; exp_fe = 0;
        if (bad != 0) begin
            exp_fe = 1; m_ext = 0; m_brk = 0;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            exp_kv = 1;
            m_code = b; m_kext = m_ext; m_kbrk = m_brk;
            held[int'({m_ext, b})] = !m_brk;
            m_ext = 0; m_brk = 0;
        end
        send_frame(b, bad);
        $display("frame %02h bad=%0d kv=%0d fe=%0d code=%02h ext=%0b brk=%0b lvl=%05b",
                 b, bad, kv_cnt - kv0, fe_cnt - fe0, key_code, key_ext, key_break,
                 {up, down, right, left, pause});
        check("key_valid_count", kv_cnt - kv0, exp_kv);
        check("frame_err_count", fe_cnt - fe0, exp_fe);
        if (exp_kv) begin
            check("key_code", key_code, m_code);
            check("key_ext", key_ext, m_kext);
            check("key_break", key_break, m_kbrk);
        end
        check("levels", {up, down, right, left, pause}, exp_lvl());
    endtask

    initial begin
        int kv0, fe0, idx, brk, bad;
        logic [7:0] code;
        bit ext;

        key_tab[0] = 9'h01D; key_tab[1] = 9'h175; key_tab[2] = 9'h01B;
        key_tab[3] = 9'h172; key_tab[4] = 9'h01C; key_tab[5] = 9'h16B;
        key_tab[6] = 9'h023; key_tab[7] = 9'h174; key_tab[8] = 9'h029;
        model_reset();

        cycles(4);
        check("reset_outputs", {up, down, right, left, pause, key_code, key_ext,
                                key_break, key_valid, frame_err}, 16'h0);
        rst = 1'b0;
        cycles(10);

        // W make then break
        xfer(8'h1D, 0); xfer(8'hF0, 0); xfer(8'h1D, 0);
        // right arrow make/break
        xfer(8'hE0, 0); xfer(8'h74, 0);
        xfer(8'hE0, 0); xfer(8'hF0, 0); xfer(8'h74, 0);
        // parity and stop errors, then good S
        xfer(8'h1B, 1); xfer(8'h1B, 2); xfer(8'h1B, 0);
        xfer(8'hF0, 0); xfer(8'h1B, 0);

        // bad start bit
        kv0 = kv_cnt; fe0 = fe_cnt;
        ps2_bit(1'b1);
        ps2_data = 1'b1;
        cycles(2 * HALF);
        m_ext = 0; m_brk = 0;
        check("start_err_fe", fe_cnt - fe0, 1);
        check("start_err_kv", kv_cnt - kv0, 0);

        // timeout after 5 data bits drops a pending E0
        xfer(8'hE0, 0);
        kv0 = kv_cnt; fe0 = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        ps2_data = 1'b1;
        cycles(TO + 100);
        m_ext = 0; m_brk = 0;
        $display("timeout kv=%0d fe=%0d", kv_cnt - kv0, fe_cnt - fe0);
        check("timeout_fe", fe_cnt - fe0, 1);
        check("timeout_kv", kv_cnt - kv0, 0);
        xfer(8'h75, 0);
        xfer(8'hE0, 0); xfer(8'h74, 0);
        xfer(8'hE0, 0); xfer(8'hF0, 0); xfer(8'h74, 0);

        // two sources of up
        xfer(8'h1D, 0); xfer(8'hE0, 0); xfer(8'h75, 0);
        xfer(8'h1D, 0);
        xfer(8'hF0, 0); xfer(8'h1D, 0);
        xfer(8'hE0, 0); xfer(8'hF0, 0); xfer(8'h75, 0);

        // reset mid-frame with keys held
        xfer(8'h1D, 0); xfer(8'hE0, 0);
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        kv0 = kv_cnt; fe0 = fe_cnt;
        rst = 1'b1;
        cycles(1);
        check("midframe_reset_outputs", {up, down, right, left, pause, key_code, key_ext,
                                         key_break, key_valid, frame_err}, 16'h0);
        rst = 1'b0;
        model_reset();
        ps2_data = 1'b1;
        cycles(TO + 100);
        $display("after reset kv=%0d fe=%0d", kv_cnt - kv0, fe_cnt - fe0);
        check("reset_no_kv", kv_cnt - kv0, 0);
        check("reset_no_fe", fe_cnt - fe0, 0);
        xfer(8'h29, 0); xfer(8'hF0, 0); xfer(8'h29, 0);

        // short clock glitch with data low must not start a frame
        kv0 = kv_cnt; fe0 = fe_cnt;
        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        cycles(3);
        ps2_clk = 1'b1;
        cycles(2);
        ps2_data = 1'b1;
        cycles(2 * HALF);
        check("glitch_kv", kv_cnt - kv0, 0);
        check("glitch_fe", fe_cnt - fe0, 0);
        xfer(8'h1C, 0); xfer(8'hF0, 0); xfer(8'h1C, 0);

        // random key sequences with occasional corrupted frames
        for (int it = 0; it < 24; it++) begin
            idx = $urandom_range(0, 9);
            if (idx < 9) begin
                ext  = key_tab[idx][8];
                code = key_tab[idx][7:0];
            end else begin
                ext = $urandom_range(0, 1);
                do code = 8'($urandom_range(0, 255));
                while (code == 8'hE0 || code == 8'hF0);
            end
            brk = $urandom_range(0, 1);
            bad = ($urandom_range(0, 7) == 0) ? 1 : 0;
            if (ext) xfer(8'hE0, 0);
            if (brk != 0) xfer(8'hF0, 0);
            xfer(code, bad);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
